serial_sub_ctrl: RTL and testbench

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_sub_ctrl_if.sv | 22 ++
 rtl/serial_sub_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/serial_sub_ctrl_if.sv
// rtl/serial_sub_ctrl_if.sv - start/operand/result bundle for serial_sub_ctrl (SERIAL_SUB_CTRL_FLAGS_EN adds ZERO/NEG)
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] DIFF;
    logic             BOUT;
`ifdef SERIAL_SUB_CTRL_FLAGS_EN
    logic             ZERO;
    logic             NEG;

    modport master (output START, A, B, input BUSY, DONE, DIFF, BOUT, ZERO, NEG);
    modport slave  (input START, A, B, output BUSY, DONE, DIFF, BOUT, ZERO, NEG);
`else
    modport master (output START, A, B, input BUSY, DONE, DIFF, BOUT);
    modport slave  (input START, A, B, output BUSY, DONE, DIFF, BOUT);
`endif
endinterface

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial LSB-first subtractor (A-B), optional ZERO/NEG flags via SERIAL_SUB_CTRL_FLAGS_EN
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    serial_sub_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_SUB_CTRL_FLAGS_EN
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
`endif

    logic             last_bit;
    logic             hs1_d, hs1_b, hs2_b;
    logic             bit_d, bit_bout;
    logic [WIDTH-1:0] res_next;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Two chained half-subtractors: a-b, then subtract the incoming borrow.
    assign hs1_d    = a_sh_q[0] ^ b_sh_q[0];
    assign hs1_b    = ~a_sh_q[0] & b_sh_q[0];
    assign bit_d    = hs1_d ^ brw_q;
    assign hs2_b    = ~hs1_d & brw_q;
    assign bit_bout = hs1_b | hs2_b;
    assign res_next = {bit_d, res_q[WIDTH-1:1]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_CTRL_FLAGS_EN
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_CTRL_FLAGS_EN
            zero_q  <= zero_d;
            neg_q   <= neg_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.START) state_d = RUN;
            RUN:     if (last_bit)  state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        res_d  = res_q;
        diff_d = diff_q;
        bout_d = bout_q;
        brw_d  = brw_q;
        cnt_d  = cnt_q;
`ifdef SERIAL_SUB_CTRL_FLAGS_EN
        zero_d = zero_q;
        neg_d  = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    a_sh_d = bus.A;
                    b_sh_d = bus.B;
                    brw_d  = 1'b0;
                    cnt_d  = '0;
                end
            end
            RUN: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d  = res_next;
                brw_d  = bit_bout;
                // Counter parks on the last index instead of wrapping.
                if (!last_bit) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    diff_d = res_next;
                    bout_d = bit_bout;
`ifdef SERIAL_SUB_CTRL_FLAGS_EN
                    zero_d = (res_next == '0);
                    // Differing signs: A<B exactly when A is negative; else the result sign.
                    neg_d  = hs1_d ? a_sh_q[0] : bit_d;
`endif
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.BUSY = (state_q == RUN);
        bus.DONE = (state_q == FIN);
        bus.DIFF = diff_q;
        bus.BOUT = bout_q;
`ifdef SERIAL_SUB_CTRL_FLAGS_EN
        bus.ZERO = zero_q;
        bus.NEG  = neg_q;
`endif
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - scoreboard bench for serial_sub_ctrl (WIDTH=8)
module tb_serial_sub_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         neg;
        int           done_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_pass;
    int   n_total;
    int   busy_cnt;
    logic [W-1:0] hold_diff;
    logic         hold_bout;
    exp_t q[$];

    serial_sub_ctrl_if #(.WIDTH(W)) bus ();

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            hold_diff = '0;
            hold_bout = 1'b0;
        end else begin
            if (bus.BUSY) begin
                busy_cnt++;
                check("diff_hold_in_run", 32'(bus.DIFF), 32'(hold_diff));
                check("bout_hold_in_run", 32'(bus.BOUT), 32'(hold_bout));
            end
            if (bus.DONE) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("diff", 32'(bus.DIFF), 32'(e.diff));
                    check("bout", 32'(bus.BOUT), 32'(e.bout));
`ifdef SERIAL_SUB_CTRL_FLAGS_EN
                    check("zero", 32'(bus.ZERO), 32'(e.zero));
                    check("neg",  32'(bus.NEG),  32'(e.neg));
`endif
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("busy_len", 32'(busy_cnt), 32'(W));
                    hold_diff = e.diff;
                    hold_bout = e.bout;
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] d, input logic bo, input logic z, input logic n, input int dc);
        exp_t e;
        e.diff = d; e.bout = bo; e.zero = z; e.neg = n; e.done_cyc = dc;
        q.push_back(e);
    endtask

    // One operation, with ignored START pulses during RUN and during FIN.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic eb, input logic ez, input logic en);
        int k;
        @(posedge clk); #1;
        bus.START = 1'b1; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        k = cyc;
        bus.START = 1'b0; bus.A = ~a; bus.B = 8'h5A;
        push_exp(ed, eb, ez, en, k + W);
        repeat (2) @(posedge clk); #1;
        bus.START = 1'b1; bus.A = 8'hFF; bus.B = 8'h11;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (5) @(posedge clk); #1;
        bus.START = 1'b1;
        @(posedge clk); #1;
        bus.START = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        n_pass = 0; n_total = 0; busy_cnt = 0;
        hold_diff = '0; hold_bout = 1'b0;
        rst = 1'b1;
        bus.START = 1'b1; bus.A = 8'h12; bus.B = 8'h34;
        repeat (3) @(posedge clk); #1;
        check("rst_busy", 32'(bus.BUSY), 32'(0));
        check("rst_done", 32'(bus.DONE), 32'(0));
        check("rst_diff", 32'(bus.DIFF), 32'(0));
        check("rst_bout", 32'(bus.BOUT), 32'(0));
        rst = 1'b0;
        bus.START = 1'b0;

        issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
        issue(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1);
        issue(8'h80, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
        issue(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
        issue(8'h7F, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0);
        issue(8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0);

        // START held high across two back-to-back operations.
        @(posedge clk); #1;
        bus.START = 1'b1; bus.A = 8'h10; bus.B = 8'h01;
        @(posedge clk); #1;
        k = cyc;
        bus.A = 8'h00; bus.B = 8'h00;
        push_exp(8'h0F, 1'b0, 1'b0, 1'b0, k + W);
        push_exp(8'h00, 1'b0, 1'b1, 1'b0, k + W + 2 + W);
        repeat (W + 2) @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (W + 1) @(posedge clk); #1;

        // Abort in the 4th RUN cycle: no DONE, registers cleared.
        bus.START = 1'b1; bus.A = 8'h20; bus.B = 8'h01;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(bus.BUSY), 32'(0));
        check("abort_done", 32'(bus.DONE), 32'(0));
        check("abort_diff", 32'(bus.DIFF), 32'(0));
        check("abort_bout", 32'(bus.BOUT), 32'(0));
        repeat (12) @(posedge clk); #1;

        issue(8'h0A, 8'h0A, 8'h00, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk); #1;
        check("scoreboard_drained", 32'(q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
